// File: rtl/fp_mul_pkg.sv
// Shared class/status bit positions and special-value builders for the FP multiplier.
// Builders return a 64-bit value that callers truncate to their operand width.
package fp_mul_pkg;

  localparam int CLS_ZERO   = 0;
  localparam int CLS_NORM   = 1;
  localparam int CLS_DENORM = 2;
  localparam int CLS_INF    = 3;
  localparam int CLS_NAN    = 4;

  localparam int ST_INV  = 0;
  localparam int ST_ZERO = 1;
  localparam int ST_INF  = 2;
  localparam int ST_NAN  = 3;

  function automatic logic [63:0] qnan_canon(input int exp_w, input int mant_w);
    return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
  endfunction

  function automatic logic [63:0] inf_of(input logic sign, input int exp_w, input int mant_w);
    return ({63'd0, sign} << (exp_w + mant_w)) | (((64'd1 << exp_w) - 64'd1) << mant_w);
  endfunction

  function automatic logic [63:0] zero_of(input logic sign, input int exp_w, input int mant_w);
    return {63'd0, sign} << (exp_w + mant_w);
  endfunction

endpackage

// File: rtl/fp_mul_special_pipe_classifier.sv
// Combinational operand classifier: exponent/fraction fields -> one-hot class and sNaN.
// The sign bit is irrelevant to classification, so only exp/mant are passed in.
module fp_operand_classifier
  import fp_mul_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] i_exp_mant,
  output logic [4:0]                      o_class,
  output logic                            o_is_snan
);

  logic [EXP_WIDTH-1:0]  w_exp;
  logic [MANT_WIDTH-1:0] w_mant;
  logic                  w_exp_ones;
  logic                  w_exp_zero;
  logic                  w_mant_zero;

  assign w_exp       = i_exp_mant[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
  assign w_mant      = i_exp_mant[MANT_WIDTH-1:0];
  assign w_exp_ones  = &w_exp;
  assign w_exp_zero  = ~|w_exp;
  assign w_mant_zero = ~|w_mant;

  assign o_class[CLS_NAN]    = w_exp_ones & ~w_mant_zero;
  assign o_class[CLS_INF]    = w_exp_ones &  w_mant_zero;
  assign o_class[CLS_DENORM] = w_exp_zero & ~w_mant_zero;
  assign o_class[CLS_ZERO]   = w_exp_zero &  w_mant_zero;
  assign o_class[CLS_NORM]   = ~w_exp_ones & ~w_exp_zero;

  // Quiet bit clear on a NaN marks it as signalling.
  assign o_is_snan = o_class[CLS_NAN] & ~w_mant[MANT_WIDTH-1];

endmodule

// File: rtl/fp_mul_special_pipe.sv
// Special-case stage of the FP multiplier: classifies operands, resolves NaN/Inf/zero
// products into a registered handshaked result, and keeps sticky flags and a special count.
module fp_mul_special_pipe
  import fp_mul_pkg::*;
#(
  parameter int IS_DOUBLE  = 0,
  parameter int EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
  parameter int MANT_WIDTH = IS_DOUBLE ? 52 : 23,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] i_op1,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] i_op2,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_is_special,
  output logic [EXP_WIDTH+MANT_WIDTH:0] o_out_result,
  output logic                          o_out_sign,
  output logic [3:0]                    o_out_status,
  output logic [4:0]                    o_out_op1_class,
  output logic [4:0]                    o_out_op2_class,
  input  logic                          i_flags_clr,
  output logic                          o_flag_invalid,
  output logic                          o_flag_denormal,
  output logic [CNT_WIDTH-1:0]          o_special_count
);

  localparam int W = EXP_WIDTH + MANT_WIDTH + 1;

  logic [4:0]           w_c1, w_c2;
  logic                 w_snan1, w_snan2;
  logic                 w_sign, w_accept, w_special, w_denorm;
  logic [3:0]           w_status;
  logic [W-1:0]         w_result, w_nan_src, w_qnan, w_inf, w_zero;
  logic [CNT_WIDTH-1:0] w_cnt_base;

  logic                 r_out_valid, r_out_is_special, r_out_sign;
  logic [W-1:0]         r_out_result;
  logic [3:0]           r_out_status;
  logic [4:0]           r_out_op1_class, r_out_op2_class;
  logic                 r_flag_invalid, r_flag_denormal;
  logic [CNT_WIDTH-1:0] r_special_count;

  fp_operand_classifier #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_cls_op1 (
    .i_exp_mant(i_op1[W-2:0]), .o_class(w_c1), .o_is_snan(w_snan1)
  );
  fp_operand_classifier #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_cls_op2 (
    .i_exp_mant(i_op2[W-2:0]), .o_class(w_c2), .o_is_snan(w_snan2)
  );

  assign w_sign    = i_op1[W-1] ^ i_op2[W-1];
  assign w_qnan    = W'(qnan_canon(EXP_WIDTH, MANT_WIDTH));
  assign w_inf     = W'(inf_of(w_sign, EXP_WIDTH, MANT_WIDTH));
  assign w_zero    = W'(zero_of(w_sign, EXP_WIDTH, MANT_WIDTH));
  assign w_nan_src = w_c1[CLS_NAN] ? i_op1 : i_op2;

  always_comb begin
    w_status = '0;
    w_result = '0;
    if (w_c1[CLS_NAN] | w_c2[CLS_NAN]) begin
      w_status[ST_NAN]       = 1'b1;
      w_status[ST_INV]       = w_snan1 | w_snan2;
      w_result               = w_nan_src;
      w_result[MANT_WIDTH-1] = 1'b1;
    end else if ((w_c1[CLS_INF] & w_c2[CLS_ZERO]) | (w_c1[CLS_ZERO] & w_c2[CLS_INF])) begin
      w_status[ST_NAN] = 1'b1;
      w_status[ST_INV] = 1'b1;
      w_result         = w_qnan;
    end else if (w_c1[CLS_INF] | w_c2[CLS_INF]) begin
      w_status[ST_INF] = 1'b1;
      w_result         = w_inf;
    end else if (w_c1[CLS_ZERO] | w_c2[CLS_ZERO]) begin
      w_status[ST_ZERO] = 1'b1;
      w_result          = w_zero;
    end
  end

  assign w_special  = |w_status[3:1];
  assign w_denorm   = w_c1[CLS_DENORM] | w_c2[CLS_DENORM];
  assign o_in_ready = ~r_out_valid | i_out_ready;
  assign w_accept   = i_in_valid & o_in_ready;
  // A clear in the same cycle as an accept wipes history first, then the new event counts.
  assign w_cnt_base = i_flags_clr ? '0 : r_special_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid      <= 1'b0;
      r_out_is_special <= 1'b0;
      r_out_result     <= '0;
      r_out_sign       <= 1'b0;
      r_out_status     <= '0;
      r_out_op1_class  <= '0;
      r_out_op2_class  <= '0;
    end else if (w_accept) begin
      r_out_valid      <= 1'b1;
      r_out_is_special <= w_special;
      r_out_result     <= w_result;
      r_out_sign       <= w_sign;
      r_out_status     <= w_status;
      r_out_op1_class  <= w_c1;
      r_out_op2_class  <= w_c2;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flag_invalid  <= 1'b0;
      r_flag_denormal <= 1'b0;
      r_special_count <= '0;
    end else if (i_flags_clr | w_accept) begin
      r_flag_invalid  <= (~i_flags_clr & r_flag_invalid)  | (w_accept & w_status[ST_INV]);
      r_flag_denormal <= (~i_flags_clr & r_flag_denormal) | (w_accept & w_denorm);
      if (w_accept & w_special & ~&w_cnt_base)
        r_special_count <= w_cnt_base + CNT_WIDTH'(1);
      else
        r_special_count <= w_cnt_base;
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_is_special = r_out_is_special;
  assign o_out_result     = r_out_result;
  assign o_out_sign       = r_out_sign;
  assign o_out_status     = r_out_status;
  assign o_out_op1_class  = r_out_op1_class;
  assign o_out_op2_class  = r_out_op2_class;
  assign o_flag_invalid   = r_flag_invalid;
  assign o_flag_denormal  = r_flag_denormal;
  assign o_special_count  = r_special_count;

endmodule
